mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/mem_arb_if.sv | 33 +++
 rtl/mem_arb.sv | 138 +++++++++++++
 tb/tb_mem_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the memory arbiter: FSM states, data-access length codes,
// RAM read latency and a helper mapping a length code to a byte count.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  localparam int RAM_RD_LAT = 1;

  // Code 2'b11 is not a legal length and is served as a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: len_bytes = 3'd1;
      LEN_HALF: len_bytes = 3'd2;
      default:  len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the fetch port, the data port and the byte-wide RAM port seen by mem_arb.
//
// Handshake: a requester raises req with stable operands and keeps them until
// the cycle its done pulses (one cycle, rdata valid); it drops req the next cycle.
interface mem_arb_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;

  logic        mm_req;
  logic        mm_we;
  logic [1:0]  mm_len;
  logic [31:0] mm_addr;
  logic [31:0] mm_wdata;
  logic [31:0] mm_rdata;
  logic        mm_done;

  logic [31:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  modport slave (
    input  if_req, if_addr, mm_req, mm_we, mm_len, mm_addr, mm_wdata, ram_rdata,
    output if_rdata, if_done, mm_rdata, mm_done, ram_addr, ram_wdata, ram_we
  );

  modport master (
    output if_req, if_addr, mm_req, mm_we, mm_len, mm_addr, mm_wdata, ram_rdata,
    input  if_rdata, if_done, mm_rdata, mm_done, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/mem_arb.sv
// Arbiter sharing one byte-wide RAM between a 4-byte fetch port and a 1/2/4-byte
// data port (little-endian). Define MEM_ARB_RR_EN for round-robin instead of mm-first.
module mem_arb
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  mem_arb_if.slave  bus,
  output logic      busy,
  output state_e    dbg_state_o
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        gnt_mm_q, gnt_mm_d;
  logic [31:0] result_q, result_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mm_rdata_q, mm_rdata_d;
  logic        grant_mm;
  logic [2:0]  cap_idx;
`ifdef MEM_ARB_RR_EN
  logic        prio_mm_q, prio_mm_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      nbytes_q   <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      gnt_mm_q   <= 1'b0;
      result_q   <= '0;
      if_rdata_q <= '0;
      mm_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      prio_mm_q  <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      gnt_mm_q   <= gnt_mm_d;
      result_q   <= result_d;
      if_rdata_q <= if_rdata_d;
      mm_rdata_q <= mm_rdata_d;
`ifdef MEM_ARB_RR_EN
      prio_mm_q  <= prio_mm_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    gnt_mm_d   = gnt_mm_q;
    result_d   = result_q;
    if_rdata_d = if_rdata_q;
    mm_rdata_d = mm_rdata_q;
    cap_idx    = cnt_q - 3'(RAM_RD_LAT);
`ifdef MEM_ARB_RR_EN
    prio_mm_d  = prio_mm_q;
    grant_mm   = bus.mm_req && (!bus.if_req || prio_mm_q);
`else
    grant_mm   = bus.mm_req;
`endif

    case (state_q)
      IDLE: begin
        if (bus.mm_req || bus.if_req) begin
          gnt_mm_d = grant_mm;
          base_d   = grant_mm ? bus.mm_addr : bus.if_addr;
          nbytes_d = grant_mm ? len_bytes(bus.mm_len) : 3'd4;
          we_d     = grant_mm && bus.mm_we;
          wdata_d  = grant_mm ? bus.mm_wdata : '0;
          cnt_d    = '0;
          result_d = '0;
          state_d  = XFER;
`ifdef MEM_ARB_RR_EN
          prio_mm_d = !grant_mm;
`endif
        end
      end
      XFER: begin
        if (we_q) begin
          if (cnt_q == nbytes_q - 3'd1) state_d = DONE;
          else                          cnt_d   = cnt_q + 3'd1;
        end else begin
          // RAM data lags its address by one cycle, so byte k lands while cnt is k+1.
          if (cnt_q >= 3'(RAM_RD_LAT))
            result_d = result_q | (32'(bus.ram_rdata) << {cap_idx, 3'b000});
          if (cnt_q == nbytes_q) begin
            state_d = DONE;
            if (gnt_mm_q) mm_rdata_d = result_d;
            else          if_rdata_d = result_d;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_we    = 1'b0;
    if (state_q == XFER && cnt_q < nbytes_q) begin
      bus.ram_addr = base_q + 32'(cnt_q);
      if (we_q) begin
        bus.ram_we    = 1'b1;
        bus.ram_wdata = 8'(wdata_q >> {cnt_q, 3'b000});
      end
    end
  end

  assign bus.if_rdata = if_rdata_q;
  assign bus.mm_rdata = mm_rdata_q;
  assign bus.if_done  = (state_q == DONE) && !gnt_mm_q;
  assign bus.mm_done  = (state_q == DONE) && gnt_mm_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: directed scenarios plus randomized traffic
// checked against a byte-array memory model and a grant-order model.
module tb_mem_arb;
  import cpu_pkg::*;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // clock / reset
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if bus();
  logic   busy;
  state_e dbg_state;

  mem_arb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // environment RAM: one-cycle read latency
  logic [7:0] env_mem [logic [31:0]];
  always @(posedge clk) begin
    if (bus.ram_we) env_mem[bus.ram_addr] = bus.ram_wdata;
    bus.ram_rdata <= env_mem.exists(bus.ram_addr) ? env_mem[bus.ram_addr] : 8'h00;
  end

  // reference model state
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] exp_q[$];
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_mm_rdata = '0;
  bit          mm_known = 1'b1;
  bit          last_mm = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] v = '0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_rd(a + 32'(k))) << (8 * k));
    return v;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    env_mem[a] = d;
    ref_mem[a] = d;
  endtask

  // driver: one uncontended transaction with cycle-by-cycle RAM-port checks
  task automatic run_txn(input bit is_mm, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata);
    int          n   = is_mm ? nbytes(len) : 4;
    bit          st  = is_mm && we;
    int          lat = st ? n + 1 : n + 2;
    logic [31:0] other_hold = is_mm ? exp_if_rdata : exp_mm_rdata;
    bit          other_known = is_mm ? 1'b1 : mm_known;
    logic [31:0] exp;
    if (!st) exp_q.push_back(ref_load(addr, n));
    last_mm = is_mm;
    for (int c = 0; c <= lat + 1; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        if (is_mm) begin
          bus.mm_req = 1'b1; bus.mm_we = we; bus.mm_len = len;
          bus.mm_addr = addr; bus.mm_wdata = wdata;
        end else begin
          bus.if_req = 1'b1; bus.if_addr = addr;
        end
      end
      if (c == lat + 1) begin
        bus.mm_req = 1'b0;
        bus.if_req = 1'b0;
      end
      @(negedge clk);
      chk("busy", 32'(busy), 32'(c >= 1 && c <= lat));
      chk("done", {30'b0, bus.mm_done, bus.if_done},
          (c == lat) ? (is_mm ? 32'd2 : 32'd1) : 32'd0);
      if (c >= 1 && c <= n) begin
        chk("ram_addr", bus.ram_addr, addr + 32'(c - 1));
        chk("ram_we", 32'(bus.ram_we), 32'(st));
        if (st) chk("ram_wdata", 32'(bus.ram_wdata), (wdata >> (8 * (c - 1))) & 32'hFF);
      end else begin
        chk("ram_we_off", 32'(bus.ram_we), 32'd0);
      end
      if (c == lat) begin
        if (!st) begin
          exp = exp_q.pop_front();
          chk("rdata", is_mm ? bus.mm_rdata : bus.if_rdata, exp);
          if (is_mm) begin exp_mm_rdata = exp; mm_known = 1'b1; end
          else exp_if_rdata = exp;
        end
        if (other_known) chk("rdata_hold", is_mm ? bus.if_rdata : bus.mm_rdata, other_hold);
      end
    end
    if (st) begin
      for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = 8'((wdata >> (8 * k)) & 32'hFF);
      mm_known = 1'b0;
    end
  endtask

  // driver: both ports request in the same cycle (mm load vs fetch); hold keeps
  // both requests asserted throughout so every IDLE cycle is a fresh contest
  task automatic contend(input int ngr, input bit hold, input logic [1:0] mlen,
                         input logic [31:0] ma, input logic [31:0] ia);
    int          dc[4];
    bit          dm[4];
    logic [31:0] dv[4];
    int          t = 0;
    int          endc;
    int          mn = nbytes(mlen);
    bit          mp = 1'b1, ip = 1'b1, wm, em, ei;
    for (int g = 0; g < ngr; g++) begin
      if (mp && ip) wm = (RR && last_mm) ? 1'b0 : 1'b1;
      else          wm = mp;
      last_mm = wm;
      dm[g]   = wm;
      dc[g]   = t + (wm ? mn + 2 : 6);
      dv[g]   = wm ? ref_load(ma, mn) : ref_load(ia, 4);
      t       = dc[g] + 1;
      if (!hold) begin
        if (wm) mp = 1'b0;
        else    ip = 1'b0;
      end
    end
    endc = t;
    for (int c = 0; c <= endc; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        bus.mm_req = 1'b1; bus.mm_we = 1'b0; bus.mm_len = mlen;
        bus.mm_addr = ma; bus.mm_wdata = '0;
        bus.if_req = 1'b1; bus.if_addr = ia;
      end
      if (!hold)
        for (int g = 0; g < ngr; g++)
          if (c == dc[g] + 1) begin
            if (dm[g]) bus.mm_req = 1'b0;
            else       bus.if_req = 1'b0;
          end
      if (c == endc) begin
        bus.mm_req = 1'b0;
        bus.if_req = 1'b0;
      end
      @(negedge clk);
      em = 1'b0; ei = 1'b0;
      for (int g = 0; g < ngr; g++)
        if (dc[g] == c) begin
          if (dm[g]) em = 1'b1;
          else       ei = 1'b1;
        end
      chk("arb_mm_done", 32'(bus.mm_done), 32'(em));
      chk("arb_if_done", 32'(bus.if_done), 32'(ei));
      for (int g = 0; g < ngr; g++)
        if (dc[g] == c) begin
          if (dm[g]) begin
            chk("arb_mm_rdata", bus.mm_rdata, dv[g]);
            exp_mm_rdata = dv[g]; mm_known = 1'b1;
          end else begin
            chk("arb_if_rdata", bus.if_rdata, dv[g]);
            exp_if_rdata = dv[g];
          end
        end
    end
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mm_req = 1'b0; bus.mm_we = 1'b0; bus.mm_len = 2'b00;
    bus.mm_addr = '0; bus.mm_wdata = '0;

    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    for (int a = 0; a < 64; a++) preload(32'h1000 + 32'(a), 8'($urandom_range(0, 255)));
    preload(32'hFFFF_FFFE, 8'h5C); preload(32'hFFFF_FFFF, 8'hA5);
    preload(32'h0, 8'h3E); preload(32'h1, 8'h71);

    // reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", {30'b0, bus.mm_done, bus.if_done}, 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_ram_addr", bus.ram_addr, 32'd0);
    chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("rst_if_rdata", bus.if_rdata, 32'd0);
    chk("rst_mm_rdata", bus.mm_rdata, 32'd0);

    // word load of 11,22,33,44 and half store then readback
    run_txn(1'b1, 1'b0, LEN_WORD, 32'h100, 32'h0);
    chk("word_load_value", exp_mm_rdata, 32'h4433_2211);
    run_txn(1'b1, 1'b1, LEN_HALF, 32'h200, 32'hAABB_CCDD);
    run_txn(1'b1, 1'b0, LEN_HALF, 32'h200, 32'h0);
    chk("half_readback", exp_mm_rdata, 32'h0000_CCDD);
    run_txn(1'b0, 1'b0, LEN_WORD, 32'h1000, 32'h0);
    run_txn(1'b1, 1'b0, 2'b11, 32'h1004, 32'h0);

    // simultaneous requests, then continuous re-requesting
    contend(2, 1'b0, LEN_WORD, 32'h1010, 32'h1020);
    contend(4, 1'b1, LEN_BYTE, 32'h1030, 32'h1008);

    // randomized traffic
    for (int i = 0; i < 24; i++) begin
      bit          is_mm = ($urandom_range(0, 3) != 0);
      bit          we    = 1'($urandom_range(0, 1));
      logic [1:0]  len   = 2'($urandom_range(0, 3));
      logic [31:0] addr  = 32'h1000 + 32'($urandom_range(0, 60));
      run_txn(is_mm, we, len, addr, $urandom);
    end

    // reset in the middle of a word store
    @(posedge clk); #1;
    bus.mm_req = 1'b1; bus.mm_we = 1'b1; bus.mm_len = LEN_WORD;
    bus.mm_addr = 32'h2000; bus.mm_wdata = 32'h5A6B_7C8D;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    bus.mm_req = 1'b0;
    @(negedge clk);
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    chk("abort_ram_we", 32'(bus.ram_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mm_rdata", bus.mm_rdata, 32'd0);
    chk("abort_if_rdata", bus.if_rdata, 32'd0);
    last_mm = 1'b0; exp_mm_rdata = '0; exp_if_rdata = '0; mm_known = 1'b1;
    ref_mem[32'h2000] = 8'h8D;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("abort_no_done", {30'b0, bus.mm_done, bus.if_done}, 32'd0);
    end
    run_txn(1'b1, 1'b0, LEN_BYTE, 32'h2000, 32'h0);
    chk("abort_partial_byte", exp_mm_rdata, 32'h0000_008D);

    // top-of-address-space accesses
    run_txn(1'b1, 1'b0, LEN_BYTE, 32'hFFFF_FFFF, 32'h0);
    chk("top_byte_zext", exp_mm_rdata, 32'h0000_00A5);
    run_txn(1'b0, 1'b0, LEN_WORD, 32'hFFFF_FFFE, 32'h0);
    chk("wrap_fetch", exp_if_rdata, 32'h713E_A55C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
